// File: rtl/ac_channel_fifo_if.sv
// ac_channel_fifo_if: ac_channel producer/consumer port bundle
interface ac_channel_fifo_if #(parameter int WIDTH = 32, parameter int DEPTH = 4);
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;
  logic [31:0] write_valid;
  logic write_ready;
  logic read_valid;
  logic read_ready;
  logic overflow;
  logic underflow;
  logic [$clog2(DEPTH):0] count;
  modport master(
    output in_data, write_valid, read_valid,
    input write_ready, read_ready, out_data, count, overflow, underflow
  );
  modport slave(
    input in_data, write_valid, read_valid,
    output write_ready, read_ready, out_data, count, overflow, underflow
  );
endinterface

// File: rtl/ac_channel_fifo.sv
// ac_channel_fifo: responder-side ac_channel FIFO with sticky overflow/underflow flags
module ac_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ac_channel_fifo_if.slave ch
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push, pop, unused_bits;
  // Readies decode the count register only, never the strobes
  assign ch.write_ready = ch.count < FULL;
  assign ch.read_ready = ch.count != '0;
  assign push = ch.write_valid[0] && ch.write_ready;
  assign pop = ch.read_valid && ch.read_ready;
  assign unused_bits = ^ch.write_valid[31:1];
  always_ff @(posedge clk)
    if (push && !rst) mem[wp] <= ch.in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      ch.count <= '0;
      ch.out_data <= '0;
      ch.overflow <= 1'b0;
      ch.underflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (pop) ch.out_data <= mem[rp];
      ch.count <= ch.count + CW'(push) - CW'(pop);
      ch.overflow <= ch.overflow | (ch.write_valid[0] & ~push);
      ch.underflow <= ch.underflow | (ch.read_valid & ~pop);
    end
  end
endmodule

// File: tb/tb_ac_channel_fifo.sv
// tb_ac_channel_fifo: scoreboard bench for ac_channel_fifo
module tb_ac_channel_fifo;
  logic clk = 1'b0;
  logic rst;
  ac_channel_fifo_if #(.WIDTH(32), .DEPTH(4)) ch();
  ac_channel_fifo #(.WIDTH(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .ch(ch));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  logic [31:0] mout;
  bit movf, munf;
  logic [63:0] sum;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask
  task automatic verify();
    check("count", 64'(ch.count), 64'(q.size()));
    check("write_ready", 64'(ch.write_ready), 64'(q.size() < 4));
    check("read_ready", 64'(ch.read_ready), 64'(q.size() > 0));
    check("out_data", 64'(ch.out_data), 64'(mout));
    check("overflow", 64'(ch.overflow), 64'(movf));
    check("underflow", 64'(ch.underflow), 64'(munf));
  endtask
  task automatic idle();
    ch.write_valid = {31'($urandom), 1'b0};
    ch.read_valid = 1'b0;
    ch.in_data = $urandom;
  endtask
  task automatic step(input bit w, input logic [31:0] d, input bit r);
    bit push, pop;
    push = w && q.size() < 4;
    pop = r && q.size() > 0;
    ch.write_valid = {31'($urandom), w};
    ch.in_data = d;
    ch.read_valid = r;
    if (pop) mout = q.pop_front();
    if (push) q.push_back(d);
    movf |= w && !push;
    munf |= r && !pop;
    @(posedge clk);
    @(negedge clk);
    idle();
    verify();
  endtask
  task automatic reset_dut();
    ch.write_valid = 32'h1;
    ch.in_data = 32'd55;
    ch.read_valid = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    q.delete();
    mout = '0;
    movf = 0;
    munf = 0;
    verify();
  endtask
  initial begin
    reset_dut();
    step(1, 3, 0); step(1, 5, 0); step(1, 7, 0); step(1, 11, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
    check("basic_last", 64'(ch.out_data), 64'd11);
    for (int i = 1; i <= 4; i++) step(1, 32'(10 * i), 0);
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      sum += 64'(ch.out_data);
    end
    check("reduce_sum", sum, 64'd100);
    check("reduce_flags", 64'({ch.overflow, ch.underflow}), 64'd0);
    for (int i = 1; i <= 5; i++) step(1, 32'(i), 0);
    check("full_ovf", 64'(ch.overflow), 64'd1);
    step(1, 9, 1);
    check("full_pop_out", 64'(ch.out_data), 64'd1);
    check("full_count", 64'(ch.count), 64'd3);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    check("full_drain_last", 64'(ch.out_data), 64'd4);
    step(0, 0, 1);
    check("empty_unf", 64'(ch.underflow), 64'd1);
    step(1, 42, 1);
    check("empty_out_hold", 64'(ch.out_data), 64'd4);
    step(0, 0, 1);
    check("empty_out", 64'(ch.out_data), 64'd42);
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(100 + i), 0);
      step(0, 0, 1);
    end
    check("wrap_last", 64'(ch.out_data), 64'd109);
    step(1, 1, 0);
    step(1, 2, 0);
    reset_dut();
    step(1, 77, 0);
    step(0, 0, 1);
    check("rst_mid_out", 64'(ch.out_data), 64'd77);
    check("rst_mid_count", 64'(ch.count), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ac_channel_fifo.md
# ac_channel_fifo

Synchronous FIFO implementing the responder side of the ac_channel port protocol. HLS-generated kernels act as producers (write_ready / write_valid / in_data) and consumers (read_ready / read_valid / out_data) on this interface. One instance connects the output channel of one kernel to the input channel of another, for example a stream producer feeding a reducer that pops four words and emits their sum. The block stores up to DEPTH words and flags protocol violations.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 4, storage depth in words; power of two, at least 2
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  write data from the producer, sampled in the write_valid cycle
- write_valid  input  32  write strobe from the producer; only bit 0 is significant, bits 31:1 are ignored
- write_ready  output  1  high when count < DEPTH
- read_valid  input  1  pop strobe from the consumer
- read_ready  output  1  high when count > 0
- out_data  output  WIDTH  registered data of the most recent successful pop
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; set by a push while full
- underflow  output  1  sticky; set by a pop while empty

## Operation
- Storage: circular array mem[DEPTH], write pointer wp and read pointer rp, each clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is kept in the count register, not derived from the pointers.
- Push condition: write_valid[0] && count < DEPTH (evaluated on the pre-edge count). On a push: mem[wp] <= in_data, then wp <= wp+1.
- Pop condition: read_valid && count > 0. On a pop: out_data <= mem[rp], then rp <= rp+1.
- Count update: count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- Push and pop in the same cycle on an empty FIFO: the push is accepted, the pop is rejected (underflow sets), and count becomes 1. There is no bypass path from in_data to out_data.
- Push and pop in the same cycle on a full FIFO: the pop is accepted, the push is rejected (overflow sets), and count becomes DEPTH-1.
- Rejected push: storage and pointers are unchanged; overflow <= 1.
- Rejected pop: out_data holds its previous value; underflow <= 1.
- overflow and underflow are cleared only by rst.
- out_data is not advanced by anything other than an accepted pop. It holds its value indefinitely, so a consumer may sample it any number of cycles after its read_valid pulse.
- write_ready and read_ready are combinational decodes of the count register only. They do not depend on write_valid or read_valid in the same cycle, so no combinational path runs from the strobes to the ready outputs.

## Timing
- Reset (rst high at an edge): wp=0, rp=0, count=0, out_data=0, overflow=0, underflow=0, so write_ready=1 and read_ready=0 in the following cycle. Memory contents are not reset. Reset overrides any push or pop in the same cycle.
- Push accepted at edge N: read_ready rises in cycle N+1 if the FIFO was empty before the push.
- Pop accepted at edge N: out_data is valid from N+1 onward. This matches a consumer that pulses read_valid in one state and reads out_data in the next.
- Pop accepted at edge N while full: write_ready rises in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- Producers pulse write_valid for exactly one cycle per word; a strobe held high for k cycles counts as k pushes.
- Reset asserted mid-stream discards all stored words. The first pop after reset returns the first word pushed after reset.

## Test plan
- Reset then idle: assert rst for 2 cycles, then release -> write_ready=1, read_ready=0, count=0, out_data=0, overflow=0, underflow=0.
- Basic order: push 3, 5, 7, 11 on consecutive cycles, then pop 4 times at one pop per 2 cycles -> out_data reads 3, 5, 7, 11, each valid the cycle after its read_valid pulse; read_ready falls after the 4th pop; count returns to 0.
- Reduce pairing: producer pushes 10, 20, 30, 40; a reducer-style consumer pops 4 words and sums them -> sum is 100; no overflow or underflow.
- Full boundary: push 1 through 5 with DEPTH=4 -> 5th push rejected, overflow=1, count=4, write_ready=0. Then issue a simultaneous push of 9 with a pop -> out_data=1, push rejected, count=3. Drain the FIFO -> out_data reads 2, 3, 4.
- Empty boundary: pop on an empty FIFO -> underflow=1, out_data unchanged. Then push 42 together with a pop in the same cycle -> count=1, out_data unchanged. Next pop -> out_data=42.
- Wrap-around and reset mid-stream: run 10 push/pop pairs with values 100..109 -> each output matches its input, pointers wrap twice. Then push 1 and 2, pulse rst, push 77, pop -> out_data=77 and count=0.
